// File: rtl/reglk_pkg.sv
// Shared types, default parameters and helpers for the register-lock controller.
package reglk_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED    = 2'd0,
        ST_CHALLENGE = 2'd1,
        ST_UNLOCKED  = 2'd2,
        ST_LOCKOUT   = 2'd3
    } reglk_state_e;

    localparam int unsigned REGLK_NUM_WORDS     = 6;
    localparam int unsigned REGLK_WORD_W        = 32;
    localparam int unsigned REGLK_KEY_W         = 32;
    localparam logic [31:0] REGLK_UNLOCK_KEY    = 32'hA5C3_0F1E;
    localparam int unsigned REGLK_UNLOCK_CYCLES = 1024;
    localparam int unsigned REGLK_MAX_FAILS     = 3;

    // Bit offset of a lock word inside the flattened lock vector.
    function automatic int unsigned reglk_word_idx(input int unsigned addr,
                                                   input int unsigned word_w);
        return addr * word_w;
    endfunction

endpackage

// File: rtl/reglk_unlock_fsm.sv
// Key-authenticated unlock sequencer with time-limited window.
// Optional failed-attempt lockout is built when REGLK_LOCKOUT_EN is defined.
module reglk_unlock_fsm
    import reglk_pkg::*;
#(
    parameter int unsigned      KEY_W         = REGLK_KEY_W,
    parameter logic [KEY_W-1:0] UNLOCK_KEY    = KEY_W'(REGLK_UNLOCK_KEY),
    parameter int unsigned      UNLOCK_CYCLES = REGLK_UNLOCK_CYCLES
`ifdef REGLK_LOCKOUT_EN
    ,
    parameter int unsigned      MAX_FAILS     = REGLK_MAX_FAILS
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             unlock_req_i,
    input  logic             key_valid_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             relock_i,
    output logic             unlocked_o,
    output logic             lockout_o
);

    localparam int unsigned TIMER_W = $clog2(UNLOCK_CYCLES + 1);

    reglk_state_e       state;
    logic [TIMER_W-1:0] timer;
    logic               key_ok;

    assign key_ok = (key_i == UNLOCK_KEY);

`ifdef REGLK_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

    logic [FAIL_W-1:0] fails;
    logic [FAIL_W-1:0] fails_inc;

    // Saturating increment of the failed-attempt count.
    assign fails_inc = (fails == FAIL_W'(MAX_FAILS)) ? fails : fails + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_LOCKED;
            timer      <= '0;
            fails      <= '0;
            unlocked_o <= 1'b0;
            lockout_o  <= 1'b0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (unlock_req_i) state <= ST_CHALLENGE;
                end
                ST_CHALLENGE: begin
                    if (key_valid_i) begin
                        if (key_ok) begin
                            state      <= ST_UNLOCKED;
                            unlocked_o <= 1'b1;
                            timer      <= TIMER_W'(UNLOCK_CYCLES - 1);
                            fails      <= '0;
                        end else begin
                            fails <= fails_inc;
                            if (fails_inc == FAIL_W'(MAX_FAILS)) begin
                                state     <= ST_LOCKOUT;
                                lockout_o <= 1'b1;
                            end else begin
                                state <= ST_LOCKED;
                            end
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (timer == '0 || relock_i) begin
                        state      <= ST_LOCKED;
                        unlocked_o <= 1'b0;
                        timer      <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    state <= ST_LOCKOUT;
                end
                default: begin
                    state      <= ST_LOCKED;
                    unlocked_o <= 1'b0;
                end
            endcase
        end
    end
`else
    assign lockout_o = 1'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_LOCKED;
            timer      <= '0;
            unlocked_o <= 1'b0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (unlock_req_i) state <= ST_CHALLENGE;
                end
                ST_CHALLENGE: begin
                    if (key_valid_i) begin
                        if (key_ok) begin
                            state      <= ST_UNLOCKED;
                            unlocked_o <= 1'b1;
                            timer      <= TIMER_W'(UNLOCK_CYCLES - 1);
                        end else begin
                            state <= ST_LOCKED;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (timer == '0 || relock_i) begin
                        state      <= ST_LOCKED;
                        unlocked_o <= 1'b0;
                        timer      <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state      <= ST_LOCKED;
                    unlocked_o <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: rtl/reglk_ctrl.sv
// Register-lock controller: set-only lock words, writable freely inside an unlock window.
// Failed-key lockout is present only when REGLK_LOCKOUT_EN is defined.
module reglk_ctrl
    import reglk_pkg::*;
#(
    parameter int unsigned      NUM_WORDS     = REGLK_NUM_WORDS,
    parameter int unsigned      WORD_W        = REGLK_WORD_W,
    parameter int unsigned      KEY_W         = REGLK_KEY_W,
    parameter logic [KEY_W-1:0] UNLOCK_KEY    = KEY_W'(REGLK_UNLOCK_KEY),
    parameter int unsigned      UNLOCK_CYCLES = REGLK_UNLOCK_CYCLES
`ifdef REGLK_LOCKOUT_EN
    ,
    parameter int unsigned      MAX_FAILS     = REGLK_MAX_FAILS
`endif
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [$clog2(NUM_WORDS)-1:0]  addr_i,
    input  logic [WORD_W-1:0]             wdata_i,
    output logic [WORD_W-1:0]             rdata_o,
    output logic                          ack_o,
    input  logic                          unlock_req_i,
    input  logic                          key_valid_i,
    input  logic [KEY_W-1:0]              key_i,
    input  logic                          relock_i,
    output logic [NUM_WORDS*WORD_W-1:0]   reglk_o,
    output logic                          unlocked_o,
    output logic                          lockout_o
);

    logic [NUM_WORDS*WORD_W-1:0] lock_q;
    logic                        in_range;
    int unsigned                 base;

    reglk_unlock_fsm #(
        .KEY_W         (KEY_W),
        .UNLOCK_KEY    (UNLOCK_KEY),
        .UNLOCK_CYCLES (UNLOCK_CYCLES)
`ifdef REGLK_LOCKOUT_EN
        ,
        .MAX_FAILS     (MAX_FAILS)
`endif
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .unlock_req_i (unlock_req_i),
        .key_valid_i  (key_valid_i),
        .key_i        (key_i),
        .relock_i     (relock_i),
        .unlocked_o   (unlocked_o),
        .lockout_o    (lockout_o)
    );

    assign in_range = (32'(addr_i) < NUM_WORDS);
    assign base     = reglk_word_idx(32'(addr_i), WORD_W);

    // Write rule follows the registered unlock flag, i.e. the state before this edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q  <= '1;
            rdata_o <= '0;
            ack_o   <= 1'b0;
        end else begin
            ack_o   <= req_i;
            rdata_o <= '0;
            if (req_i && in_range) begin
                rdata_o <= lock_q[base +: WORD_W];
                if (we_i) begin
                    if (unlocked_o) lock_q[base +: WORD_W] <= wdata_i;
                    else            lock_q[base +: WORD_W] <= lock_q[base +: WORD_W] | wdata_i;
                end
            end
        end
    end

    assign reglk_o = lock_q;

endmodule
